// File: rtl/riscv_state_pkg.sv
// Shared core-side types for the data-memory path: access size encoding and
// a helper giving the byte count of a legal access size.
package riscv_state_pkg;

  typedef enum logic [2:0] {
    BYTE  = 3'd0,
    HWORD = 3'd1,
    WORD  = 3'd2,
    DWORD = 3'd3
  } dmem_size_t;

  // Only the low two bits matter; larger encodings are rejected as misaligned upstream.
  function automatic logic [3:0] size_bytes(input logic [2:0] size);
    return 4'd1 << size[1:0];
  endfunction

endpackage

// File: rtl/riscv_dmem_align.sv
// Combinational alignment helper: byte-enable generation, misalignment
// detection and store-lane replication for one data-memory access.
module riscv_dmem_align
  import riscv_state_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]   adr_i,
  input  logic [2:0]        size_i,
  input  logic [XLEN-1:0]   d_i,
  output logic [XLEN/8-1:0] be_o,
  output logic              misaligned_o,
  output logic [XLEN-1:0]   d_o
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  logic [NB-1:0]   mask;
  logic [OFFW-1:0] off;
  logic [3:0]      nbytes;

  assign off    = adr_i[OFFW-1:0];
  assign nbytes = size_bytes(size_i);

  always_comb begin
    misaligned_o = 1'b0;
    case (size_i)
      BYTE:    misaligned_o = 1'b0;
      HWORD:   misaligned_o = adr_i[0];
      WORD:    misaligned_o = (adr_i[1:0] != 2'b00);
      // A doubleword cannot fit a 32-bit bus at all.
      DWORD:   misaligned_o = (XLEN == 32) ? 1'b1 : (adr_i[2:0] != 3'b000);
      default: misaligned_o = 1'b1;
    endcase
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < NB; i++) begin
      mask[i] = (unsigned'(i) < 32'(nbytes));
    end
  end

  assign be_o = mask << off;

  always_comb begin
    d_o = d_i;
    case (size_i)
      BYTE:    d_o = {NB{d_i[7:0]}};
      HWORD:   d_o = {(NB/2){d_i[15:0]}};
      WORD:    d_o = {(XLEN/32){d_i[31:0]}};
      default: d_o = d_i;
    endcase
  end

endmodule

// File: rtl/riscv_dmem_ctrl.sv
// Data-memory controller: accepts one load/store from the memory stage, checks
// alignment and range, runs a single bus transaction and returns a one-cycle response.
module riscv_dmem_ctrl
  import riscv_state_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] MEM_BASE = '0,
  parameter logic [XLEN-1:0] MEM_SIZE = XLEN'('h1_0000)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              dmem_req_i,
  input  logic [XLEN-1:0]   dmem_adr_i,
  input  logic [2:0]        dmem_size_i,
  input  logic              dmem_we_i,
  input  logic [XLEN-1:0]   dmem_d_i,
  output logic              dmem_stall_o,
  output logic              dmem_ack_o,
  output logic              dmem_err_o,
  output logic              dmem_misaligned_o,
  output logic              dmem_page_fault_o,
  output logic [XLEN-1:0]   dmem_q_o,
  output logic              bus_req_o,
  output logic [XLEN-1:0]   bus_adr_o,
  output logic              bus_we_o,
  output logic [XLEN/8-1:0] bus_be_o,
  output logic [XLEN-1:0]   bus_d_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic              bus_err_i,
  input  logic [XLEN-1:0]   bus_q_i
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] RSP   = 2'd2;
  localparam logic [1:0] FAULT = 2'd3;

  logic [1:0]      state_q, state_d;
  logic            bus_req_q, bus_req_d;
  logic [XLEN-1:0] bus_adr_q, bus_adr_d;
  logic            bus_we_q, bus_we_d;
  logic [NB-1:0]   bus_be_q, bus_be_d;
  logic [XLEN-1:0] bus_d_q, bus_d_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] q_q, q_d;

  logic [NB-1:0]   al_be;
  logic            al_misaligned;
  logic [XLEN-1:0] al_d;
  logic [XLEN:0]   acc_end;
  logic [XLEN:0]   win_end;
  logic            out_of_range;

  riscv_dmem_align #(
    .XLEN(XLEN)
  ) u_align (
    .adr_i        (dmem_adr_i),
    .size_i       (dmem_size_i),
    .d_i          (dmem_d_i),
    .be_o         (al_be),
    .misaligned_o (al_misaligned),
    .d_o          (al_d)
  );

  // One extra bit so an access wrapping past the top of the address space is rejected.
  assign acc_end      = {1'b0, dmem_adr_i} + (XLEN+1)'(size_bytes(dmem_size_i));
  assign win_end      = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};
  assign out_of_range = (dmem_adr_i < MEM_BASE) || (acc_end > win_end);

  assign dmem_stall_o = dmem_req_i & (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    bus_req_d = bus_req_q;
    bus_adr_d = bus_adr_q;
    bus_we_d  = bus_we_q;
    bus_be_d  = bus_be_q;
    bus_d_d   = bus_d_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    mis_d     = 1'b0;
    q_d       = q_q;
    case (state_q)
      IDLE: begin
        if (dmem_req_i) begin
          if (al_misaligned) begin
            state_d = FAULT;
            mis_d   = 1'b1;
          end else if (out_of_range) begin
            state_d = FAULT;
            err_d   = 1'b1;
          end else begin
            state_d   = REQ;
            bus_req_d = 1'b1;
            bus_adr_d = {dmem_adr_i[XLEN-1:OFFW], {OFFW{1'b0}}};
            bus_we_d  = dmem_we_i;
            bus_be_d  = al_be;
            bus_d_d   = al_d;
          end
        end
      end
      REQ: begin
        if (bus_gnt_i) begin
          state_d   = RSP;
          bus_req_d = 1'b0;
        end
      end
      RSP: begin
        // An error completes the data phase even if rvalid arrives with it.
        if (bus_err_i) begin
          state_d  = IDLE;
          err_d    = 1'b1;
          bus_we_d = 1'b0;
          bus_be_d = '0;
        end else if (bus_rvalid_i) begin
          state_d  = IDLE;
          ack_d    = 1'b1;
          q_d      = bus_q_i;
          bus_we_d = 1'b0;
          bus_be_d = '0;
        end
      end
      FAULT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      bus_req_q <= 1'b0;
      bus_adr_q <= '0;
      bus_we_q  <= 1'b0;
      bus_be_q  <= '0;
      bus_d_q   <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      mis_q     <= 1'b0;
      q_q       <= '0;
    end else begin
      state_q   <= state_d;
      bus_req_q <= bus_req_d;
      bus_adr_q <= bus_adr_d;
      bus_we_q  <= bus_we_d;
      bus_be_q  <= bus_be_d;
      bus_d_q   <= bus_d_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      mis_q     <= mis_d;
      q_q       <= q_d;
    end
  end

  assign dmem_ack_o        = ack_q;
  assign dmem_err_o        = err_q;
  assign dmem_misaligned_o = mis_q;
  assign dmem_page_fault_o = 1'b0;
  assign dmem_q_o          = q_q;
  assign bus_req_o         = bus_req_q;
  assign bus_adr_o         = bus_adr_q;
  assign bus_we_o          = bus_we_q;
  assign bus_be_o          = bus_be_q;
  assign bus_d_o           = bus_d_q;

endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// Directed bench for riscv_dmem_ctrl (XLEN=32): a table of load/store vectors with
// hand-computed bus fields and responses, plus reset and idle-bus corner cases.
module tb_riscv_dmem_ctrl;

  logic        clk_i;
  logic        rst_ni;
  logic        dmem_req_i;
  logic [31:0] dmem_adr_i;
  logic [2:0]  dmem_size_i;
  logic        dmem_we_i;
  logic [31:0] dmem_d_i;
  logic        dmem_stall_o;
  logic        dmem_ack_o;
  logic        dmem_err_o;
  logic        dmem_misaligned_o;
  logic        dmem_page_fault_o;
  logic [31:0] dmem_q_o;
  logic        bus_req_o;
  logic [31:0] bus_adr_o;
  logic        bus_we_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_d_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic        bus_err_i;
  logic [31:0] bus_q_i;

  int nChecks = 0;
  int nFails  = 0;

  // kind: 0 = ack, 1 = bus error, 2 = misaligned, 3 = out of range
  typedef struct {
    logic [31:0] adr;
    logic [2:0]  size;
    logic        we;
    logic [31:0] d;
    int          gntDly;
    int          rvDly;
    logic        busErr;
    logic [31:0] busQ;
    logic        holdReq;
    logic [1:0]  kind;
    logic [31:0] expAdr;
    logic [3:0]  expBe;
    logic [31:0] expD;
  } vec_t;

  vec_t vecs[15];

  riscv_dmem_ctrl #(
    .XLEN     (32),
    .MEM_BASE (32'h0),
    .MEM_SIZE (32'h1_0000)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .dmem_req_i        (dmem_req_i),
    .dmem_adr_i        (dmem_adr_i),
    .dmem_size_i       (dmem_size_i),
    .dmem_we_i         (dmem_we_i),
    .dmem_d_i          (dmem_d_i),
    .dmem_stall_o      (dmem_stall_o),
    .dmem_ack_o        (dmem_ack_o),
    .dmem_err_o        (dmem_err_o),
    .dmem_misaligned_o (dmem_misaligned_o),
    .dmem_page_fault_o (dmem_page_fault_o),
    .dmem_q_o          (dmem_q_o),
    .bus_req_o         (bus_req_o),
    .bus_adr_o         (bus_adr_o),
    .bus_we_o          (bus_we_o),
    .bus_be_o          (bus_be_o),
    .bus_d_o           (bus_d_o),
    .bus_gnt_i         (bus_gnt_i),
    .bus_rvalid_i      (bus_rvalid_i),
    .bus_err_i         (bus_err_i),
    .bus_q_i           (bus_q_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic vec_t mkVec(input logic [31:0] adr, input logic [2:0] size,
                                 input logic we, input logic [31:0] d,
                                 input int gd, input int rd, input logic berr,
                                 input logic [31:0] q, input logic hold,
                                 input logic [1:0] kind, input logic [31:0] eadr,
                                 input logic [3:0] ebe, input logic [31:0] ed);
    vec_t v;
    v.adr = adr; v.size = size; v.we = we; v.d = d;
    v.gntDly = gd; v.rvDly = rd; v.busErr = berr; v.busQ = q;
    v.holdReq = hold; v.kind = kind;
    v.expAdr = eadr; v.expBe = ebe; v.expD = ed;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkNoResp(input string tag);
    checkOutput({tag, " ack idle"}, dmem_ack_o, 1'b0);
    checkOutput({tag, " err idle"}, dmem_err_o, 1'b0);
    checkOutput({tag, " mis idle"}, dmem_misaligned_o, 1'b0);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk_i);
    dmem_req_i  = 1'b1;
    dmem_adr_i  = v.adr;
    dmem_size_i = v.size;
    dmem_we_i   = v.we;
    dmem_d_i    = v.d;
    checkOutput({tag, " stall at accept"}, dmem_stall_o, 1'b0);
    @(negedge clk_i);
    if (!v.holdReq) dmem_req_i = 1'b0;
    if (v.kind >= 2) begin
      checkOutput({tag, " misaligned pulse"}, dmem_misaligned_o, v.kind == 2);
      checkOutput({tag, " range err pulse"}, dmem_err_o, v.kind == 3);
      checkOutput({tag, " ack on fault"}, dmem_ack_o, 1'b0);
      checkOutput({tag, " bus_req on fault"}, bus_req_o, 1'b0);
      @(negedge clk_i);
      dmem_req_i = 1'b0;
      checkNoResp({tag, " after fault"});
      checkOutput({tag, " bus_req after fault"}, bus_req_o, 1'b0);
    end else begin
      checkOutput({tag, " bus_req"}, bus_req_o, 1'b1);
      checkOutput({tag, " bus_adr"}, bus_adr_o, v.expAdr);
      checkOutput({tag, " bus_be"}, bus_be_o, v.expBe);
      checkOutput({tag, " bus_we"}, bus_we_o, v.we);
      if (v.we) checkOutput({tag, " bus_d"}, bus_d_o, v.expD);
      for (int c = 0; c < v.gntDly; c++) begin
        checkOutput({tag, " bus_req held"}, bus_req_o, 1'b1);
        checkOutput({tag, " bus_adr held"}, bus_adr_o, v.expAdr);
        checkNoResp({tag, " wait gnt"});
        if (v.holdReq) checkOutput({tag, " stall in REQ"}, dmem_stall_o, 1'b1);
        @(negedge clk_i);
      end
      if (v.holdReq) checkOutput({tag, " stall at gnt"}, dmem_stall_o, 1'b1);
      bus_gnt_i = 1'b1;
      @(negedge clk_i);
      bus_gnt_i = 1'b0;
      checkOutput({tag, " bus_req after gnt"}, bus_req_o, 1'b0);
      for (int c = 0; c < v.rvDly; c++) begin
        checkNoResp({tag, " wait rvalid"});
        if (v.holdReq) checkOutput({tag, " stall in RSP"}, dmem_stall_o, 1'b1);
        @(negedge clk_i);
      end
      if (v.holdReq) checkOutput({tag, " stall at rvalid"}, dmem_stall_o, 1'b1);
      bus_rvalid_i = 1'b1;
      bus_err_i    = v.busErr;
      bus_q_i      = v.busQ;
      @(negedge clk_i);
      bus_rvalid_i = 1'b0;
      bus_err_i    = 1'b0;
      bus_q_i      = 32'h5555_AAAA;
      dmem_req_i   = 1'b0;
      checkOutput({tag, " ack"}, dmem_ack_o, v.kind == 0);
      checkOutput({tag, " err"}, dmem_err_o, v.kind == 1);
      checkOutput({tag, " mis"}, dmem_misaligned_o, 1'b0);
      checkOutput({tag, " page_fault"}, dmem_page_fault_o, 1'b0);
      if (v.kind == 0) checkOutput({tag, " dmem_q"}, dmem_q_o, v.busQ);
      @(negedge clk_i);
      checkNoResp({tag, " after resp"});
    end
  endtask

  initial begin
    rst_ni       = 1'b0;
    dmem_req_i   = 1'b0;
    dmem_adr_i   = '0;
    dmem_size_i  = '0;
    dmem_we_i    = 1'b0;
    dmem_d_i     = '0;
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b0;
    bus_err_i    = 1'b0;
    bus_q_i      = '0;

    //                adr           sz  we d             gd rd berr q             hold kind eadr          ebe      ed
    vecs[0]  = mkVec(32'h0000_0100, 3'd2, 0, 32'h0,          0, 0, 0, 32'hDEAD_BEEF, 0, 2'd0, 32'h0000_0100, 4'hF,    32'h0);
    vecs[1]  = mkVec(32'h0000_0103, 3'd0, 1, 32'h0000_00A5,  0, 0, 0, 32'h0,         0, 2'd0, 32'h0000_0100, 4'b1000, 32'hA5A5_A5A5);
    vecs[2]  = mkVec(32'h0000_0101, 3'd1, 0, 32'h0,          0, 0, 0, 32'h0,         0, 2'd2, 32'h0,         4'h0,    32'h0);
    vecs[3]  = mkVec(32'h0001_0000, 3'd2, 0, 32'h0,          0, 0, 0, 32'h0,         0, 2'd3, 32'h0,         4'h0,    32'h0);
    vecs[4]  = mkVec(32'h0000_0200, 3'd2, 0, 32'h0,          5, 3, 0, 32'h1234_5678, 1, 2'd0, 32'h0000_0200, 4'hF,    32'h0);
    vecs[5]  = mkVec(32'h0000_0204, 3'd2, 1, 32'hCAFE_F00D,  0, 0, 1, 32'h0BAD_0BAD, 0, 2'd1, 32'h0000_0204, 4'hF,    32'hCAFE_F00D);
    vecs[6]  = mkVec(32'h0000_010E, 3'd1, 1, 32'h1234_ABCD,  1, 0, 0, 32'h0,         0, 2'd0, 32'h0000_010C, 4'b1100, 32'hABCD_ABCD);
    vecs[7]  = mkVec(32'h0000_FFFF, 3'd0, 0, 32'h0,          0, 1, 0, 32'h1122_3344, 0, 2'd0, 32'h0000_FFFC, 4'b1000, 32'h0);
    vecs[8]  = mkVec(32'h0000_FFFE, 3'd1, 0, 32'h0,          0, 0, 0, 32'h7788_99AA, 0, 2'd0, 32'h0000_FFFC, 4'b1100, 32'h0);
    vecs[9]  = mkVec(32'h0000_0008, 3'd3, 0, 32'h0,          0, 0, 0, 32'h0,         0, 2'd2, 32'h0,         4'h0,    32'h0);
    vecs[10] = mkVec(32'h0000_0000, 3'd5, 0, 32'h0,          0, 0, 0, 32'h0,         0, 2'd2, 32'h0,         4'h0,    32'h0);
    vecs[11] = mkVec(32'hFFFF_FFFC, 3'd2, 0, 32'h0,          0, 0, 0, 32'h0,         0, 2'd3, 32'h0,         4'h0,    32'h0);
    vecs[12] = mkVec(32'h0000_0000, 3'd2, 1, 32'h89AB_CDEF,  0, 0, 0, 32'h0,         0, 2'd0, 32'h0000_0000, 4'hF,    32'h89AB_CDEF);
    vecs[13] = mkVec(32'h0000_0101, 3'd2, 0, 32'h0,          0, 0, 0, 32'h0,         0, 2'd2, 32'h0,         4'h0,    32'h0);
    vecs[14] = mkVec(32'h0000_0022, 3'd1, 0, 32'h0,          2, 2, 1, 32'h0,         0, 2'd1, 32'h0000_0020, 4'b1100, 32'h0);

    #12;
    checkOutput("reset bus_req", bus_req_o, 1'b0);
    checkOutput("reset bus_we", bus_we_o, 1'b0);
    checkOutput("reset bus_be", bus_be_o, 4'h0);
    checkOutput("reset dmem_q", dmem_q_o, 32'h0);
    checkOutput("reset page_fault", dmem_page_fault_o, 1'b0);
    checkNoResp("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Bus handshake signals must be ignored while idle.
    @(negedge clk_i);
    bus_gnt_i    = 1'b1;
    bus_rvalid_i = 1'b1;
    bus_err_i    = 1'b1;
    @(negedge clk_i);
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b0;
    bus_err_i    = 1'b0;
    checkNoResp("idle bus noise");
    checkOutput("idle noise bus_req", bus_req_o, 1'b0);

    // Reset asserted while the controller waits in RSP.
    @(negedge clk_i);
    dmem_req_i  = 1'b1;
    dmem_adr_i  = 32'h0000_0300;
    dmem_size_i = 3'd2;
    dmem_we_i   = 1'b1;
    dmem_d_i    = 32'h0F0F_0F0F;
    @(negedge clk_i);
    dmem_req_i = 1'b0;
    checkOutput("rst seq bus_req", bus_req_o, 1'b1);
    bus_gnt_i = 1'b1;
    @(negedge clk_i);
    bus_gnt_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    checkOutput("midrst bus_req", bus_req_o, 1'b0);
    checkOutput("midrst bus_we", bus_we_o, 1'b0);
    checkOutput("midrst bus_be", bus_be_o, 4'h0);
    checkOutput("midrst dmem_q", dmem_q_o, 32'h0);
    checkNoResp("midrst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    bus_rvalid_i = 1'b1;
    bus_q_i      = 32'hFFFF_0000;
    @(negedge clk_i);
    bus_rvalid_i = 1'b0;
    checkNoResp("late rvalid");
    checkOutput("late rvalid dmem_q", dmem_q_o, 32'h0);
    @(negedge clk_i);
    checkNoResp("late rvalid +1");
    checkOutput("late rvalid bus_req", bus_req_o, 1'b0);

    applyStimulus(vecs[0], 100);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
